// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle ops, Booth multiplier and optional restoring divider (enable with ALU_SEQ_DIV_EN)
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 dz,
  output logic                 illegal
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_NOR  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b01111;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t          state;
  logic [W:0]      acc;
  logic [W-1:0]    q;
  logic            q1;
  logic [W-1:0]    m;
  logic [CW-1:0]   cnt;

  function automatic logic [2*W-1:0] sx(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  function automatic logic [2*W-1:0] zx(input logic [W-1:0] v);
    return {{W{1'b0}}, v};
  endfunction

  logic [CW-1:0]   sh;
  logic [CW-1:0]   nsh;
  logic            sc;
  logic [2*W-1:0]  sc_res;

  assign sh  = B[CW-1:0];
  assign nsh = -sh;

  // single-cycle result selection; rotates combine a shift by sh with the complementary shift by -sh mod W
  always_comb begin
    sc = 1'b1;
    sc_res = '0;
    case (opcode)
      OP_ADD:  sc_res = sx(A + B);
      OP_SUB:  sc_res = sx(A - B);
      OP_NEG:  sc_res = sx(-A);
      OP_AND:  sc_res = zx(A & B);
      OP_OR:   sc_res = zx(A | B);
      OP_XOR:  sc_res = zx(A ^ B);
      OP_NOR:  sc_res = zx(~(A | B));
      OP_NOT:  sc_res = zx(~A);
      OP_SHR:  sc_res = zx(A >> sh);
      OP_SHRA: sc_res = zx($signed(A) >>> sh);
      OP_SHL:  sc_res = zx(A << sh);
      OP_ROR:  sc_res = zx((A >> sh) | (A << nsh));
      OP_ROL:  sc_res = zx((A << sh) | (A >> nsh));
      default: sc = 1'b0;
    endcase
  end

  logic [W:0]      mext;
  logic [W:0]      bsum;
  logic [W:0]      bacc;
  logic [W-1:0]    bq;

  assign mext = {m[W-1], m};
  assign bacc = {bsum[W], bsum[W:1]};
  assign bq   = {bsum[0], q[W-1:1]};

  // radix-2 Booth step on a W+1-bit accumulator so the most-negative multiplicand cannot overflow
  always_comb begin
    bsum = ({q[0], q1} == 2'b01) ? acc + mext : ({q[0], q1} == 2'b10) ? acc - mext : acc;
  end

`ifdef ALU_SEQ_DIV_EN
  logic            nq;
  logic            nr;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W:0]      rsh;
  logic [W:0]      trial;
  logic [W:0]      dacc;
  logic [W-1:0]    dq;
  logic            ge;
  logic [W-1:0]    quo;
  logic [W-1:0]    rem;

  assign a_mag = A[W-1] ? -A : A;
  assign b_mag = B[W-1] ? -B : B;
  assign rsh   = {acc[W-1:0], q[W-1]};
  assign trial = rsh - {1'b0, m};
  assign ge    = ~trial[W];
  assign dq    = {q[W-2:0], ge};
  assign quo   = nq ? -dq : dq;
  assign rem   = nr ? -dacc[W-1:0] : dacc[W-1:0];

  // restoring divide step on magnitudes; signs are reapplied to quotient and remainder at the end
  always_comb begin
    dacc = ge ? trial : rsh;
  end
`endif

  // control FSM with registered outputs and iteration datapath
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      C       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
      acc     <= '0;
      q       <= '0;
      q1      <= 1'b0;
      m       <= '0;
      cnt     <= '0;
`ifdef ALU_SEQ_DIV_EN
      nq      <= 1'b0;
      nr      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dz      <= 1'b0;
          illegal <= 1'b0;
          if (sc) begin
            C    <= sc_res;
            done <= 1'b1;
          end else if (opcode == OP_MUL) begin
            acc   <= '0;
            q     <= A;
            q1    <= 1'b0;
            m     <= B;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (opcode == OP_DIV && B == '0) begin
            C    <= {A, {W{1'b1}}};
            dz   <= 1'b1;
            done <= 1'b1;
          end else if (opcode == OP_DIV) begin
            acc   <= '0;
            q     <= a_mag;
            m     <= b_mag;
            nq    <= A[W-1] ^ B[W-1];
            nr    <= A[W-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
`endif
          else begin
            done    <= 1'b1;
            illegal <= (opcode != OP_NOP);
          end
        end
        MUL: begin
          acc <= bacc;
          q   <= bq;
          q1  <= q[0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            C     <= {bacc[W-1:0], bq};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          acc <= dacc;
          q   <= dq;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            C     <= {rem, quo};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (WIDTH=32); honours ALU_SEQ_DIV_EN
module tb_alu_seq;
  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] c;
  logic        busy;
  logic        done;
  logic        dz;
  logic        illegal;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_c = '0;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110,
    ROR = 5'b00111, ROL = 5'b01000, SHR = 5'b01001, SHRA = 5'b01010, SHL = 5'b01011,
    XOR_ = 5'b01101, NOR_ = 5'b01110, DIV = 5'b01111, MUL = 5'b10000, NEG = 5'b10001,
    NOT_ = 5'b10010, NOP = 5'b11010;
  localparam logic [4:0] OPS [19] = '{ADD, SUB, AND_, OR_, ROR, ROL, SHR, SHRA, SHL, XOR_, NOR_,
    DIV, MUL, NEG, NOT_, NOP, 5'b00000, 5'b11111, 5'b10011};

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .A(a), .B(b),
    .C(c), .busy(busy), .done(done), .dz(dz), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [63:0] prev, output logic [63:0] r,
                                output logic mdz, output logic mill, output int lat);
    longint sx, sy, qq, rr;
    logic [31:0] t;
    int s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s = int'(y[4:0]);
    mdz = 1'b0;
    mill = 1'b0;
    lat = 1;
    r = prev;
    t = '0;
    case (op)
      ADD:  begin t = x + y; r = longint'($signed(t)); end
      SUB:  begin t = x - y; r = longint'($signed(t)); end
      NEG:  begin t = -x; r = longint'($signed(t)); end
      AND_: r = {32'h0, x & y};
      OR_:  r = {32'h0, x | y};
      XOR_: r = {32'h0, x ^ y};
      NOR_: r = {32'h0, ~(x | y)};
      NOT_: r = {32'h0, ~x};
      SHR:  r = {32'h0, x >> s};
      SHRA: begin t = $signed(x) >>> s; r = {32'h0, t}; end
      SHL:  r = {32'h0, x << s};
      ROR:  begin t = x; repeat (s) t = {t[0], t[31:1]}; r = {32'h0, t}; end
      ROL:  begin t = x; repeat (s) t = {t[30:0], t[31]}; r = {32'h0, t}; end
      MUL:  begin r = sx * sy; lat = 33; end
      DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (y == 0) begin
          r = {x, 32'hFFFFFFFF};
          mdz = 1'b1;
        end else begin
          qq = sx / sy;
          rr = sx % sy;
          r = {rr[31:0], qq[31:0]};
          lat = 33;
        end
`else
        mill = 1'b1;
`endif
      end
      NOP: ;
      default: mill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  // issues one op and waits (bounded) for done; after a multi-cycle op it also steps past FIN
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] gc, output logic gdz, output logic gil,
                        output int lat, output int bc, output bit ok);
    @(negedge clock);
    start = 1'b1; opcode = op; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1; bc = 0; ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(posedge clock); #1;
      lat++;
    end
    ok = done;
    gc = c; gdz = dz; gil = illegal;
    if (lat > 1) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({c, busy, done, dz, illegal} !== 68'h0) begin
      errors++;
      $display("FAIL reset: got C=%h busy=%b done=%b dz=%b ill=%b, want all 0", c, busy, done, dz, illegal);
    end
    @(negedge clock) clear = 1'b1;
    model_c = '0;
  endtask

  task automatic test_add();
    logic [63:0] gc; logic gdz, gil; int lat, bc; bit ok;
    run_op(ADD, 32'h7FFFFFFF, 32'h1, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'hFFFFFFFF_80000000 || lat !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL add_ovf: got C=%h lat=%0d busy_cycles=%0d, want C=ffffffff80000000 lat=1 busy_cycles=0", gc, lat, bc);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || c !== 64'hFFFFFFFF_80000000) begin
      errors++;
      $display("FAIL done_pulse: got done=%b C=%h, want done=0 C held", done, c);
    end
    model_c = 64'hFFFFFFFF_80000000;
  endtask

  task automatic test_mul();
    logic [63:0] gc; logic gdz, gil; int lat, bc; bit ok;
    run_op(MUL, 32'hFFFFFFFD, 32'd7, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'hFFFFFFFF_FFFFFFEB || lat !== 33 || bc !== 32) begin
      errors++;
      $display("FAIL mul_neg3x7: got C=%h lat=%0d busy_cycles=%0d, want C=ffffffffffffffeb lat=33 busy_cycles=32", gc, lat, bc);
    end
    model_c = 64'hFFFFFFFF_FFFFFFEB;
    run_op(MUL, 32'h80000000, 32'h80000000, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'h40000000_00000000 || lat !== 33) begin
      errors++;
      $display("FAIL mul_minxmin: got C=%h lat=%0d, want C=4000000000000000 lat=33", gc, lat);
    end
    model_c = 64'h40000000_00000000;
  endtask

  task automatic test_div();
    logic [63:0] gc, ec; logic gdz, gil; int lat, bc; bit ok;
    logic [31:0] xs [3] = '{32'd100, 32'hFFFFFF9C, 32'h80000000};
    logic [31:0] ys [3] = '{32'd7, 32'd7, 32'hFFFFFFFF};
    logic [63:0] es [3] = '{64'h00000002_0000000E, 64'hFFFFFFFE_FFFFFFF2, 64'h00000000_80000000};
    for (int i = 0; i < 3; i++) begin
      run_op(DIV, xs[i], ys[i], gc, gdz, gil, lat, bc, ok);
`ifdef ALU_SEQ_DIV_EN
      ec = es[i];
      checks++;
      if (!ok || gc !== ec || gdz !== 1'b0 || gil !== 1'b0 || lat !== 33 || bc !== 32) begin
        errors++;
        $display("FAIL div_%0d: got C=%h dz=%b ill=%b lat=%0d, want C=%h dz=0 ill=0 lat=33", i, gc, gdz, gil, lat, ec);
      end
`else
      ec = model_c;
      checks++;
      if (!ok || gc !== ec || gil !== 1'b1 || lat !== 1) begin
        errors++;
        $display("FAIL div_off_%0d: got C=%h ill=%b lat=%0d, want C=%h ill=1 lat=1 (expected %h only with divider)", i, gc, gil, lat, ec, es[i]);
      end
`endif
      model_c = ec;
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] gc, ec; logic gdz, gil; int lat, bc; bit ok;
    run_op(DIV, 32'd5, 32'd0, gc, gdz, gil, lat, bc, ok);
`ifdef ALU_SEQ_DIV_EN
    ec = 64'h00000005_FFFFFFFF;
    checks++;
    if (!ok || gc !== ec || gdz !== 1'b1 || gil !== 1'b0 || lat !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL div_zero: got C=%h dz=%b ill=%b lat=%0d, want C=%h dz=1 ill=0 lat=1", gc, gdz, gil, lat, ec);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (dz !== 1'b1 || c !== ec) begin
      errors++;
      $display("FAIL dz_hold: got dz=%b C=%h, want dz=1 C=%h", dz, c, ec);
    end
`else
    ec = model_c;
    checks++;
    if (!ok || gc !== ec || gdz !== 1'b0 || gil !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL div_zero_off: got C=%h dz=%b ill=%b lat=%0d, want C=%h dz=0 ill=1 lat=1", gc, gdz, gil, lat, ec);
    end
`endif
    model_c = ec;
  endtask

  task automatic test_nop_illegal();
    logic [63:0] gc; logic gdz, gil; int lat, bc; bit ok;
    run_op(ADD, 32'd5, 32'd6, gc, gdz, gil, lat, bc, ok);
    model_c = 64'd11;
    run_op(NOP, 32'hDEAD, 32'hBEEF, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'd11 || gil !== 1'b0 || gdz !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL nop: got C=%h ill=%b dz=%b lat=%0d, want C=11 ill=0 dz=0 lat=1", gc, gil, gdz, lat);
    end
    run_op(5'b11111, 32'h1234, 32'h5678, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'd11 || gil !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL illegal_op: got C=%h ill=%b lat=%0d, want C=11 ill=1 lat=1", gc, gil, lat);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (illegal !== 1'b1 || c !== 64'd11 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_hold: got ill=%b C=%h done=%b, want ill=1 C=11 done=0", illegal, c, done);
    end
    run_op(AND_, 32'hF0F0, 32'hFF00, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'hF000 || gil !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got C=%h ill=%b, want C=f000 ill=0", gc, gil);
    end
    model_c = 64'hF000;
  endtask

  task automatic test_abort();
    logic [63:0] gc; logic gdz, gil; int lat, bc; bit ok;
    bit seen;
    @(negedge clock);
    start = 1'b1; opcode = MUL; a = 32'hFFFFFFFD; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    start = 1'b1; opcode = ADD; a = 32'd1; b = 32'd1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || c !== model_c) begin
      errors++;
      $display("FAIL start_in_busy: got busy=%b done=%b C=%h, want busy=1 done=0 C=%h", busy, done, c, model_c);
    end
    repeat (5) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    #1;
    checks++;
    if ({c, busy, done, dz, illegal} !== 68'h0) begin
      errors++;
      $display("FAIL abort_clear: got C=%h busy=%b done=%b dz=%b ill=%b, want all 0", c, busy, done, dz, illegal);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) clear = 1'b1;
    model_c = '0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy || c !== 64'h0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet: got activity (done/busy/C) after abort, want none");
    end
    run_op(ROL, 32'h80000001, 32'd1, gc, gdz, gil, lat, bc, ok);
    checks++;
    if (!ok || gc !== 64'h3 || lat !== 1) begin
      errors++;
      $display("FAIL rol_after_abort: got C=%h lat=%0d, want C=3 lat=1", gc, lat);
    end
    model_c = 64'h3;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] exp1;
    @(negedge clock);
    start = 1'b1; opcode = MUL; a = 32'd1000; b = 32'hFFFFFFFE;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(posedge clock); #1; n++; end
    exp1 = 64'hFFFFFFFF_FFFFF830;
    checks++;
    if (done !== 1'b1 || c !== exp1) begin
      errors++;
      $display("FAIL b2b_mul: got done=%b C=%h, want done=1 C=%h", done, c, exp1);
    end
    @(negedge clock);
    start = 1'b1; opcode = ADD; a = 32'd1; b = 32'd2;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || c !== exp1) begin
      errors++;
      $display("FAIL start_in_fin: got done=%b C=%h, want done=0 C=%h", done, c, exp1);
    end
    @(negedge clock);
    start = 1'b1; opcode = XOR_; a = 32'hFF00FF00; b = 32'h0FF00FF0;
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || c !== 64'h00000000_F0F0F0F0) begin
      errors++;
      $display("FAIL b2b_first: got done=%b C=%h, want done=1 C=00000000f0f0f0f0", done, c);
    end
    @(negedge clock);
    opcode = SUB; a = 32'd3; b = 32'd10;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || c !== 64'hFFFFFFFF_FFFFFFF9) begin
      errors++;
      $display("FAIL b2b_second: got done=%b C=%h, want done=1 C=fffffffffffffff9", done, c);
    end
    model_c = 64'hFFFFFFFF_FFFFFFF9;
  endtask

  task automatic test_random(input int cnt);
    logic [63:0] gc, ec; logic gdz, gil, edz, eil; int lat, bc, elat; bit ok;
    logic [4:0] op; logic [31:0] x, y;
    for (int i = 0; i < cnt; i++) begin
      op = OPS[$urandom_range(0, 18)];
      x = pick();
      y = pick();
      model(op, x, y, model_c, ec, edz, eil, elat);
      run_op(op, x, y, gc, gdz, gil, lat, bc, ok);
      checks++;
      if (!ok || gc !== ec || gdz !== edz || gil !== eil || lat !== elat) begin
        errors++;
        $display("FAIL random op=%b a=%h b=%h: got C=%h dz=%b ill=%b lat=%0d, want C=%h dz=%b ill=%b lat=%0d",
                 op, x, y, gc, gdz, gil, lat, ec, edz, eil, elat);
      end
      checks++;
      if (bc !== elat - 1) begin
        errors++;
        $display("FAIL random_busy op=%b: got busy_cycles=%0d, want %0d", op, bc, elat - 1);
      end
      model_c = ec;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div_zero();
    test_nop_illegal();
    test_abort();
    test_back_to_back();
    test_random(80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: requests an operation, sampled on the rising edge.
REQ-005 The block SHALL have port opcode, input, 5 bits: operation select, using the CPU spec encoding.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each: operands, captured when start is accepted.
REQ-007 The block SHALL have port C, output, 2*WIDTH bits: registered result.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multi-cycle operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking C valid.
REQ-010 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, valid with done.
REQ-011 The block SHALL have port illegal, output, 1 bit: unsupported-opcode flag, valid with done.

Function
REQ-012 The block SHALL implement FSM states IDLE, MUL, DIV and FIN.
- Start is accepted only in IDLE; it is ignored in every other state.
REQ-013 Single-cycle operations SHALL load C and pulse done on the edge after start is accepted, and the FSM SHALL remain in IDLE.
- Single-cycle operations: add 00011, sub 00100, and 00101, or 00110, xor 01101, nor 01110, neg 10001, not 10010, shr 01001, shra 01010, shl 01011, ror 00111, rol 01000.
REQ-014 Add, sub and neg results SHALL be two's-complement, with C[2W-1:W] sign-extended from result bit W-1 and the carry discarded.
REQ-015 Logic, shift and rotate results SHALL occupy C[W-1:0], with C[2W-1:W] zero.
- Shift/rotate amount is B[log2(WIDTH)-1:0].
- neg and not use A only.
REQ-016 For mul 10000, the block SHALL compute the signed W x W product (radix-2 Booth, one step per cycle).
- busy is high for exactly WIDTH cycles after acceptance.
- The next edge enters FIN, loads the full 2W product into C and pulses done.
- Total latency start to done: WIDTH+1 edges.
REQ-017 For div 01111, the block SHALL compute signed A / B (restoring, one quotient bit per cycle, truncation toward zero).
- C[W-1:0] = quotient; C[2W-1:W] = remainder, which takes the sign of A.
- Latency is identical to mul.
REQ-018 For div with B = 0, the block SHALL skip iteration: on the next edge C = {A, all ones}, dz = 1 and done pulses.
REQ-019 For div with A = most-negative and B = -1, the block SHALL return quotient = A, remainder 0 and dz = 0.
REQ-020 For nop 11010, the block SHALL pulse done and hold C unchanged.
REQ-021 For any other opcode, the block SHALL pulse done with illegal = 1 and hold C unchanged.
REQ-022 The block SHALL hold C stable between done pulses.
- dz and illegal hold until the next accepted start.
REQ-023 In FIN, the block SHALL return to IDLE on the next edge.
- busy is low and done is high for that single cycle.
- A start in FIN is ignored.
- Back-to-back issue is possible from the cycle after done.

Reset
REQ-024 While clear = 0, the block SHALL force state IDLE, C = 0, busy = 0, done = 0, dz = 0, illegal = 0 and all iteration registers to 0.
REQ-025 Assertion of clear mid-operation SHALL abort the operation with no done pulse.
- The first start accepted after clear deasserts begins a fresh operation.

Configuration
REQ-026 When macro ALU_SEQ_DIV_EN is defined, the divider datapath and DIV state SHALL be compiled in, behaving per REQ-017 to REQ-019.
REQ-027 When ALU_SEQ_DIV_EN is undefined, no divider logic SHALL be synthesised, and opcode 01111 SHALL behave as an illegal opcode per REQ-021.

Verification (WIDTH = 32)
REQ-028 The bench SHALL drive add with A = 0x7FFFFFFF, B = 1 -> next edge C = 0xFFFFFFFF_80000000, done = 1, busy never high.
REQ-029 The bench SHALL drive mul with A = -3, B = 7 -> busy high 32 cycles, then C = 0xFFFFFFFF_FFFFFFEB with done on edge 33.
REQ-030 The bench SHALL drive div with A = 100, B = 7 -> done on edge 33 with C = 0x00000002_0000000E; repeat with A = -100 -> C = 0xFFFFFFFE_FFFFFFF2.
REQ-031 The bench SHALL drive div with A = 5, B = 0 -> next edge C = 0x00000005_FFFFFFFF, dz = 1; without ALU_SEQ_DIV_EN -> illegal = 1 and C unchanged.
REQ-032 The bench SHALL drive mul, pulse start with add during busy, and assert clear at cycle 10.
- Required: the add is ignored, no done occurs, all outputs are 0, and a subsequent rol with A = 0x80000001, B = 1 gives C = 0x00000000_00000003.
